// File: rtl/sign_extender_12to16.sv
// sign_extender_12to16: widens a 12-bit immediate to 16 bits, combinationally and as a registered valid-qualified copy
module sign_extender_12to16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bit12_in,
  input  logic [1:0]  ext_mode,
  input  logic        in_valid,
  output logic [15:0] bit16_out,
  output logic [15:0] bit16_q,
  output logic        out_valid
);
  always_comb bit16_out = ext_mode == 2'b01 ? {4'b0000, bit12_in} :
                          ext_mode == 2'b10 ? {{3{bit12_in[11]}}, bit12_in, 1'b0} :
                                              {{4{bit12_in[11]}}, bit12_in};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit16_q   <= 16'h0000;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) bit16_q <= bit16_out;
    end
  end
endmodule

// File: tb/tb_sign_extender_12to16.sv
// tb_sign_extender_12to16: vector table, directed register sequences and randomized checks against an arithmetic model
module tb_sign_extender_12to16;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] bit12_in;
  logic [1:0]  ext_mode;
  logic        in_valid;
  logic [15:0] bit16_out;
  logic [15:0] bit16_q;
  logic        out_valid;
  int total = 0;
  int bad = 0;

  sign_extender_12to16 dut (
    .clk(clk), .rst_n(rst_n), .bit12_in(bit12_in), .ext_mode(ext_mode),
    .in_valid(in_valid), .bit16_out(bit16_out), .bit16_q(bit16_q), .out_valid(out_valid)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [11:0] x;
    logic [1:0]  m;
    logic [15:0] e;
  } vec_t;

  function automatic logic [15:0] ref_ext(logic [11:0] x, logic [1:0] m);
    int v;
    v = (m != 2'b01 && int'(x) >= 2048) ? int'(x) - 4096 : int'(x);
    if (m == 2'b10) v = v * 2;
    return 16'(v);
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vt[12];
    logic [15:0] mq;
    logic        mv;
    vt[0]  = '{12'h000, 2'b00, 16'h0000};
    vt[1]  = '{12'h003, 2'b00, 16'h0003};
    vt[2]  = '{12'h803, 2'b00, 16'hF803};
    vt[3]  = '{12'hFFF, 2'b00, 16'hFFFF};
    vt[4]  = '{12'h800, 2'b00, 16'hF800};
    vt[5]  = '{12'h7FF, 2'b00, 16'h07FF};
    vt[6]  = '{12'h803, 2'b01, 16'h0803};
    vt[7]  = '{12'h803, 2'b10, 16'hF006};
    vt[8]  = '{12'h7FF, 2'b10, 16'h0FFE};
    vt[9]  = '{12'hFFF, 2'b10, 16'hFFFE};
    vt[10] = '{12'hA5A, 2'b11, 16'hFA5A};
    vt[11] = '{12'hFFF, 2'b01, 16'h0FFF};
    rst_n = 1'b0; in_valid = 1'b0; bit12_in = '0; ext_mode = '0;
    for (int i = 0; i < 12; i++) begin
      bit12_in = vt[i].x;
      ext_mode = vt[i].m;
      #5;
      chk($sformatf("comb_vec%0d", i), bit16_out, vt[i].e);
    end
    step();
    step();
    chk("reset_q", bit16_q, 16'h0000);
    chk("reset_valid", {15'b0, out_valid}, 16'h0000);
    rst_n = 1'b1; ext_mode = 2'b00;
    step();
    in_valid = 1'b1; bit12_in = 12'h803;
    step();
    chk("seq1_q", bit16_q, 16'hF803);
    chk("seq1_valid", {15'b0, out_valid}, 16'h0001);
    bit12_in = 12'h003;
    step();
    chk("seq2_q", bit16_q, 16'h0003);
    chk("seq2_valid", {15'b0, out_valid}, 16'h0001);
    in_valid = 1'b0; bit12_in = 12'h555;
    step();
    chk("drop_q", bit16_q, 16'h0003);
    chk("drop_valid", {15'b0, out_valid}, 16'h0000);
    rst_n = 1'b0; in_valid = 1'b1; bit12_in = 12'h7FF;
    #1;
    chk("rstprio_comb_pre", bit16_out, 16'h07FF);
    step();
    chk("rstprio_q", bit16_q, 16'h0000);
    chk("rstprio_valid", {15'b0, out_valid}, 16'h0000);
    chk("rstprio_comb_post", bit16_out, 16'h07FF);
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    mq = 16'h0000; mv = 1'b0;
    for (int i = 0; i < 300; i++) begin
      logic [15:0] e;
      rst_n    = ($urandom_range(0, 15) != 0);
      in_valid = $urandom_range(0, 1) == 1;
      bit12_in = 12'($urandom);
      ext_mode = 2'($urandom);
      e = ref_ext(bit12_in, ext_mode);
      #1;
      chk("rand_comb", bit16_out, e);
      if (!rst_n) begin
        mq = 16'h0000; mv = 1'b0;
      end else begin
        mv = in_valid;
        if (in_valid) mq = e;
      end
      step();
      chk("rand_q", bit16_q, mq);
      chk("rand_valid", {15'b0, out_valid}, {15'b0, mv});
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sign_extender_12to16.md
# sign_extender_12to16

Widens a 12-bit two's-complement immediate to 16 bits for the processor datapath, e.g. the immediate fields feeding the ALU and branch-target adder. It has a zero-latency combinational output for in-cycle datapath use. It also has a registered, valid-qualified copy for pipelined consumers. A mode input selects sign extension (default), zero extension, or sign extension with a left shift by one for halfword-scaled branch offsets.

## Interface
Parameters: none. Widths are fixed at 12 in and 16 out.

Ports:
- clk  input  1  single clock; all registers update on the rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk
- bit12_in  input  12  immediate value, treated as two's complement
- ext_mode  input  2  00 sign-extend, 01 zero-extend, 10 sign-extend then shift left 1, 11 treated as 00
- in_valid  input  1  qualifies bit12_in/ext_mode for the registered path
- bit16_out  output  16  combinational extended result
- bit16_q  output  16  registered extended result
- out_valid  output  1  registered; high when bit16_q holds a result captured from a valid input

Clock and reset: one clock (clk). Reset rst_n is synchronous and active-low.

## Operation
- Sign-extend (ext_mode 00 or 11): bit16_out = {4{bit12_in[11]}, bit12_in}.
- Zero-extend (01): bit16_out = {4'b0000, bit12_in}.
- Shift mode (10): bit16_out = {3{bit12_in[11]}, bit12_in, 1'b0}.
  - The result equals 2 × the signed input value and always fits in 16 bits.
  - No overflow condition exists.
- bit16_out depends only on bit12_in and ext_mode.
  - It is independent of clk, rst_n and in_valid.
  - It is never X when its inputs are known.
- Registered path, on each rising clk edge:
  - If rst_n = 0: bit16_q ← 16'h0000, out_valid ← 0.
  - Else if in_valid = 1: bit16_q ← the current bit16_out value, out_valid ← 1.
  - Else: bit16_q holds its value, out_valid ← 0.
- Value range: signed inputs map as follows.
  - Sign modes cover −2048..2047.
  - Shift mode covers −4096..4094, even values only.
  - Zero-extend mode covers 0..4095.

## Timing
- bit16_out: purely combinational, zero cycles of latency. It settles within the same cycle as the input change, well under a 5 ns window in simulation.
- bit16_q/out_valid: one-cycle latency. A valid input presented before edge N appears after edge N.
- out_valid is a one-cycle pulse per accepted input. Back-to-back valid inputs give out_valid high on consecutive cycles, each with the new value.
- No backpressure. Every valid input is accepted.
- Reset behaviour:
  - Reset takes priority over in_valid.
  - An in_valid asserted in the reset cycle is dropped.
  - bit16_q = 0 and out_valid = 0 from the first edge with rst_n low.
  - The combinational output is unaffected by reset.
- Before the first reset edge, the register contents are undefined. Consumers must not sample bit16_q until reset has been applied.

## Test plan
- Sign mode, bit12_in = 12'h000 → bit16_out = 16'h0000. bit12_in = 12'h003 → 16'h0003. Checked 5 ns after each input change.
- Sign mode negative and boundary values:
  - bit12_in = 12'h803 (−2045) → bit16_out = 16'hF803.
  - 12'hFFF → 16'hFFFF.
  - 12'h800 → 16'hF800.
  - 12'h7FF → 16'h07FF.
- Zero-extend, bit12_in = 12'h803 → bit16_out = 16'h0803. Shift mode:
  - 12'h803 → 16'hF006.
  - 12'h7FF → 16'h0FFE.
  - 12'hFFF → 16'hFFFE.
- Mode 11 with bit12_in = 12'hA5A → bit16_out = 16'hFA5A, identical to mode 00.
- Registered path:
  - Hold rst_n = 0 for 2 edges → bit16_q = 0, out_valid = 0.
  - Release reset, then drive in_valid = 1 with 12'h803, then 12'h003 on consecutive edges. Expect out_valid = 1 for two cycles and bit16_q = 16'hF803, then 16'h0003.
  - Drop in_valid → out_valid = 0 and bit16_q holds 16'h0003.
- Reset priority: assert in_valid = 1 with 12'h7FF while rst_n = 0 → after the edge, bit16_q = 0 and out_valid = 0, while bit16_out = 16'h07FF throughout.
